// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (core=port 0, aux=port 1) single-port dmem arbiter; optional lock via DMEM_ARB_LOCK_EN. Ports: clk, reset (async active-low), req/we/amp/addr/wdata/lock per port in, gnt/rvalid/rdata per port out, memwrite/amp/daddr/writedata to dmem, readdata from dmem.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAXHOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [3:0]        amp0,
  input  logic [3:0]        amp1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              memwrite,
  output logic [3:0]        amp,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAXHOLD);
  logic          ptr, ptr_n;
  logic [HW-1:0] hold, hold_n;
  logic          g0, g1, rd0, rd1;
`ifdef DMEM_ARB_LOCK_EN
  logic          lk, lk_id, lk_n, lk_id_n, own_req;
`else
  logic          unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr     <= 1'b1;
      hold    <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lk      <= 1'b0;
      lk_id   <= 1'b0;
`endif
    end else begin
      ptr     <= ptr_n;
      hold    <= hold_n;
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= readdata;
      if (rd1) rdata1 <= readdata;
`ifdef DMEM_ARB_LOCK_EN
      lk      <= lk_n;
      lk_id   <= lk_id_n;
`endif
    end
  // ptr holds the last granted port; a tie goes to the other one
  always_comb begin
`ifdef DMEM_ARB_LOCK_EN
    own_req = lk & (lk_id ? req1 : req0);
    g1      = reset & (own_req ? lk_id :
              (req0 & req1 & hold == HMAX) ? ~ptr : req1 & (~req0 | ~ptr));
    g0      = reset & req0 & ~g1;
    // any grant re-decides ownership; no grant means the owner dropped its request
    lk_n    = g0 ? lock0 : g1 & lock1;
    lk_id_n = g1;
`else
    g1      = reset & req1 & (~req0 | ~ptr);
    g0      = reset & req0 & ~g1;
`endif
    ptr_n   = (g0 | g1) ? g1 : ptr;
    hold_n  = ~(g0 | g1) ? '0 : (g1 != ptr) ? HW'(1) : (hold == HMAX) ? hold : hold + 1'b1;
    rd0     = g0 & ~we0;
    rd1     = g1 & ~we1;
  end
  always_comb begin
    gnt0      = g0;
    gnt1      = g1;
    memwrite  = (g0 & we0) | (g1 & we1);
    amp       = g0 ? amp0 : g1 ? amp1 : 4'b0;
    daddr     = g1 ? addr1 : addr0;
    writedata = g1 ? wdata1 : wdata0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  logic clk = 0, reset = 0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [3:0] amp0 = 0, amp1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, memwrite;
  logic [31:0] rdata0, rdata1, daddr, writedata, readdata;
  logic [3:0] amp;
  logic [31:0] hmem [16];
  logic [31:0] rmem [16];
  logic        erv [2];
  logic [31:0] erd [2];
  int total = 0, bad = 0;
  int last = 1, owner = -1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAXHOLD(8)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .amp0(amp0), .amp1(amp1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .memwrite(memwrite), .amp(amp), .daddr(daddr),
    .writedata(writedata), .readdata(readdata));

  assign readdata = hmem[daddr[5:2]];
  always @(posedge clk)
    if (memwrite)
      for (int i = 0; i < 4; i++)
        if (amp[i]) hmem[daddr[5:2]][8*i +: 8] <= writedata[8*i +: 8];

  function automatic int pick();
    if (owner == 0 && req0) return 0;
    if (owner == 1 && req1) return 1;
    if (req0 && req1) return 1 - last;
    return req0 ? 0 : req1 ? 1 : -1;
  endfunction

  task automatic model_reset();
    last = 1; owner = -1;
    erv[0] = 0; erv[1] = 0; erd[0] = '0; erd[1] = '0;
  endtask

  task automatic advance();
    int g, idx;
    logic w, l;
    logic [3:0] m;
    logic [31:0] d;
    g = pick(); l = 0;
    @(posedge clk);
    erv[0] = 0; erv[1] = 0;
    if (g >= 0) begin
      w = g == 1 ? we1 : we0;
      m = g == 1 ? amp1 : amp0;
      d = g == 1 ? wdata1 : wdata0;
      l = g == 1 ? lock1 : lock0;
      idx = g == 1 ? int'(addr1[5:2]) : int'(addr0[5:2]);
      if (w) begin
        for (int i = 0; i < 4; i++) if (m[i]) rmem[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        erv[g] = 1; erd[g] = rmem[idx];
      end
      last = g;
    end
`ifdef DMEM_ARB_LOCK_EN
    owner = (g >= 0 && l) ? g : -1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    @(negedge clk); @(negedge clk);
    model_reset();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; req0 = 1; req1 = 1; we0 = 1; we1 = 1; amp0 = 4'hf; amp1 = 4'hf;
    @(negedge clk); @(negedge clk);
    total++;
    if ({gnt0, gnt1, rvalid0, rvalid1, memwrite} !== 5'b0 || amp !== 4'b0 || rdata0 !== 0 || rdata1 !== 0) begin
      bad++; $display("FAIL reset_state gnt=%b%b rv=%b%b mw=%b amp=%h rd0=%h rd1=%h want all zero", gnt1, gnt0, rvalid1, rvalid0, memwrite, amp, rdata0, rdata1);
    end
    model_reset();
    reset = 1; addr0 = 0; addr1 = 32'h4; wdata0 = $urandom; wdata1 = $urandom;
    #1 total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL reset_first_tie gnt=%b%b want 01", gnt1, gnt0); end
    advance();
    #1 total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin bad++; $display("FAIL reset_second_tie gnt=%b%b want 10", gnt1, gnt0); end
    advance();
    req0 = 0; req1 = 0; we1 = 0;
  endtask

  task automatic test_init_writes();
    for (int i = 0; i < 16; i++) begin
      req0 = 1; we0 = 1; amp0 = 4'hf; addr0 = 32'(i * 4); wdata0 = $urandom;
      #1 total++;
      if (gnt0 !== 1'b1 || memwrite !== 1'b1 || amp !== 4'hf || daddr !== 32'(i * 4) || writedata !== wdata0) begin
        bad++; $display("FAIL init_write i=%0d gnt0=%b mw=%b amp=%h daddr=%h wd=%h want 1 1 f %h %h", i, gnt0, memwrite, amp, daddr, writedata, i * 4, wdata0);
      end
      advance();
      total++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL init_write_rvalid i=%0d rv=%b%b want 00", i, rvalid1, rvalid0); end
    end
    req0 = 0; we0 = 0;
  endtask

  task automatic test_alternate();
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 8; i++) begin
      #1 total++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1) || daddr !== (i % 2 == 1 ? 32'h20 : 32'h10)) begin
        bad++; $display("FAIL alt_gnt i=%0d gnt=%b%b daddr=%h want port %0d", i, gnt1, gnt0, daddr, i % 2);
      end
      advance();
      total++;
      if (rvalid0 !== (i % 2 == 0) || rvalid1 !== (i % 2 == 1) || rdata0 !== erd[0] || rdata1 !== erd[1]) begin
        bad++; $display("FAIL alt_rdata i=%0d rv=%b%b rd0=%h rd1=%h want rd0=%h rd1=%h", i, rvalid1, rvalid0, rdata0, rdata1, erd[0], erd[1]);
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; amp0 = 4'hf; addr0 = 32'h8; wdata0 = 32'h0;
    advance();
    amp0 = 4'b0011; wdata0 = 32'hAABBCCDD;
    #1 total++;
    if (memwrite !== 1'b1 || amp !== 4'b0011 || daddr !== 32'h8 || writedata !== 32'hAABBCCDD) begin
      bad++; $display("FAIL wr_strobe mw=%b amp=%b daddr=%h wd=%h want 1 0011 8 aabbccdd", memwrite, amp, daddr, writedata);
    end
    advance();
    we0 = 0;
    advance();
    total++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 32'h0000CCDD) begin
      bad++; $display("FAIL wr_readback rv=%b%b rd0=%h want 01 0000ccdd", rvalid1, rvalid0, rdata0);
    end
    req0 = 0;
  endtask

  task automatic test_idle();
    req0 = 0; req1 = 0; we0 = 1; we1 = 1; amp0 = 4'hf; amp1 = 4'hf;
    #1 total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || memwrite !== 1'b0 || amp !== 4'b0) begin
      bad++; $display("FAIL idle_comb gnt=%b%b mw=%b amp=%h want 0", gnt1, gnt0, memwrite, amp);
    end
    advance();
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== erd[0] || rdata1 !== erd[1]) begin
      bad++; $display("FAIL idle_rvalid rv=%b%b rd0=%h rd1=%h want 00 %h %h", rvalid1, rvalid0, rdata0, rdata1, erd[0], erd[1]);
    end
    we0 = 0; we1 = 0;
  endtask

  task automatic test_random();
    int g;
    logic em;
    logic [3:0] eamp;
    for (int i = 0; i < 300; i++) begin
      req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
      amp0 = 4'($urandom); amp1 = 4'($urandom); lock0 = ($urandom % 4) == 0; lock1 = ($urandom % 4) == 0;
      addr0 = 32'($urandom_range(0, 15)) << 2; addr1 = 32'($urandom_range(0, 15)) << 2;
      wdata0 = $urandom; wdata1 = $urandom;
      g = pick();
      em = g == 0 ? we0 : g == 1 ? we1 : 1'b0;
      eamp = g == 0 ? amp0 : g == 1 ? amp1 : 4'b0;
      #1 total++;
      if (gnt0 !== (g == 0) || gnt1 !== (g == 1) || memwrite !== em || amp !== eamp ||
          (g >= 0 && daddr !== (g == 1 ? addr1 : addr0)) || (g >= 0 && writedata !== (g == 1 ? wdata1 : wdata0))) begin
        bad++; $display("FAIL rand_comb i=%0d gnt=%b%b mw=%b amp=%h daddr=%h want port %0d mw=%b amp=%h", i, gnt1, gnt0, memwrite, amp, daddr, g, em, eamp);
      end
      advance();
      total++;
      if (rvalid0 !== erv[0] || rvalid1 !== erv[1] || rdata0 !== erd[0] || rdata1 !== erd[1]) begin
        bad++; $display("FAIL rand_read i=%0d rv=%b%b rd0=%h rd1=%h want rv=%b%b rd0=%h rd1=%h", i, rvalid1, rvalid0, rdata0, rdata1, erv[1], erv[0], erd[0], erd[1]);
      end
    end
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic test_fairness();
    int den = 0, maxden = 0;
    do_reset();
    req0 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 60; i++) begin
      req1 = i % 2 == 1;
      #1 total++;
      if (gnt0 !== (pick() == 0) || gnt1 !== (pick() == 1)) begin
        bad++; $display("FAIL fair_gnt i=%0d gnt=%b%b want port %0d", i, gnt1, gnt0, pick());
      end
      if (req1 && !gnt1) den++; else if (gnt1) den = 0;
      if (den > maxden) maxden = den;
      advance();
    end
    total++;
    if (maxden > 8) begin bad++; $display("FAIL fair_starve max_denied=%0d want <=8", maxden); end
    req0 = 0; req1 = 0;
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req0 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h20;
    advance();
    req1 = 1;
    for (int i = 0; i < 4; i++) begin
      lock1 = i < 3;
      #1 total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin bad++; $display("FAIL lock_hold i=%0d gnt=%b%b want 10", i, gnt1, gnt0); end
      advance();
    end
    lock1 = 0;
    #1 total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL lock_release gnt=%b%b want 01", gnt1, gnt0); end
    advance();
    req0 = 0; req1 = 0;
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    req1 = 1; we1 = 0; addr1 = 32'h20;
    #1 total++;
    if (gnt1 !== 1'b1) begin bad++; $display("FAIL mid_grant gnt1=%b want 1", gnt1); end
    #1 reset = 0;
    #1 total++;
    if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin bad++; $display("FAIL mid_gnt_in_reset gnt=%b%b want 00", gnt1, gnt0); end
    @(negedge clk);
    model_reset();
    reset = 1; req1 = 0;
    total++;
    if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin bad++; $display("FAIL mid_dropped rv1=%b rd1=%h want 0 0", rvalid1, rdata1); end
    req0 = 1; req1 = 1; we0 = 0; addr0 = 32'h10;
    #1 total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL mid_first_tie gnt=%b%b want 01", gnt1, gnt0); end
    advance();
    total++;
    if (rvalid1 !== 1'b0 || rdata1 !== 32'h0 || rvalid0 !== 1'b1 || rdata0 !== erd[0]) begin
      bad++; $display("FAIL mid_after rv=%b%b rd0=%h rd1=%h want 01 %h 0", rvalid1, rvalid0, rdata0, rdata1, erd[0]);
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    model_reset();
    test_reset();
    test_init_writes();
    test_alternate();
    test_write_read();
    test_idle();
    test_random();
    test_fairness();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
